// File: rtl/cmos_dvp_pattern_gen.sv
// cmos_dvp_pattern_gen: synthetic OmniVision-style DVP source producing vsync/href/data test frames.
module cmos_dvp_pattern_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_BLANK  = 144,
    parameter int unsigned V_FRONT  = 16,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_BACK   = 8,
    parameter int unsigned V_SYNC   = 4
) (
    input  logic        clk_cmos,
    input  logic        rst,
    input  logic        gen_en,
    input  logic [1:0]  pattern_sel,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [7:0]  cmos_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, FRONT, ACTIVE, BACK, SYNC} state_t;
    localparam logic [11:0] PIX_LAST = 12'(H_ACTIVE + H_BLANK - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    state_t      state, state_n;
    logic [11:0] pix_cnt, line_cnt, pix_n, line_n, lines;
    logic [1:0]  pat, pat_n;
    logic [7:0]  data_n;
    logic        href_n, start, done_n;
    always_comb begin
        lines   = state == FRONT ? 12'(V_FRONT) : state == ACTIVE ? 12'(V_ACTIVE) :
                  state == BACK ? 12'(V_BACK) : 12'(V_SYNC);
        state_n = state;
        pix_n   = '0;
        line_n  = '0;
        if (state == IDLE)
            state_n = gen_en ? FRONT : IDLE;
        else if (pix_cnt != PIX_LAST) begin
            pix_n  = pix_cnt + 12'd1;
            line_n = line_cnt;
        end else if (line_cnt != lines - 12'd1)
            line_n = line_cnt + 12'd1;
        else
            state_n = state == FRONT ? ACTIVE : state == ACTIVE ? BACK : state == BACK ? SYNC :
                      gen_en ? FRONT : IDLE;
        // pattern is captured only when a new frame begins
        start  = state_n == FRONT && (state == IDLE || state == SYNC);
        pat_n  = start ? pattern_sel : pat;
        href_n = state_n == ACTIVE && pix_n < H_ACT;
        done_n = state_n == SYNC && state != SYNC;
        data_n = !href_n ? 8'h00 : pat_n == 2'd0 ? pix_n[7:0] : pat_n == 2'd1 ? line_n[7:0] :
                 pat_n == 2'd2 ? {8{pix_n[3] ^ line_n[3]}} : pix_n[7:0] + frame_cnt[7:0];
    end
    always_ff @(posedge clk_cmos) begin
        if (rst) begin
            state      <= IDLE;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            pat        <= '0;
            cmos_vsync <= 1'b0;
            cmos_href  <= 1'b0;
            cmos_data  <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            pix_cnt    <= pix_n;
            line_cnt   <= line_n;
            pat        <= pat_n;
            cmos_vsync <= state_n == FRONT || state_n == ACTIVE || state_n == BACK;
            cmos_href  <= href_n;
            cmos_data  <= data_n;
            frame_done <= done_n;
            frame_cnt  <= done_n ? frame_cnt + 16'd1 : frame_cnt;
            busy       <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_cmos_dvp_pattern_gen.sv
// tb_cmos_dvp_pattern_gen: frame-position reference model feeding a per-cycle and a per-pixel scoreboard.
module tb_cmos_dvp_pattern_gen;
    localparam int HA = 8, HB = 4, VF = 2, VA = 4, VB = 1, VS = 1;
    localparam int HT = HA + HB;
    localparam int FRAME = (VF + VA + VB + VS) * HT;
    localparam int VS_LEN = (VF + VA + VB) * HT;

    typedef struct packed {
        logic        vs;
        logic        hr;
        logic [7:0]  data;
        logic        fd;
        logic        busy;
        logic [15:0] fcnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gen_en = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        cmos_vsync, cmos_href, frame_done, busy;
    logic [7:0]  cmos_data;
    logic [15:0] frame_cnt;

    obs_t       exp_q[$];
    logic [7:0] pix_q[$];
    int vectors = 0;
    int miscompares = 0;

    cmos_dvp_pattern_gen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_FRONT(VF), .V_ACTIVE(VA),
                           .V_BACK(VB), .V_SYNC(VS)) dut (
        .clk_cmos(clk), .rst(rst), .gen_en(gen_en), .pattern_sel(pattern_sel),
        .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_data(cmos_data),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy));

    always #5 clk = ~clk;

    function automatic obs_t predict(input bit run, input int t, input int pat, input logic [15:0] fcnt);
        obs_t o;
        int line, x, y;
        line = t / HT;
        x = t % HT;
        y = line - VF;
        o.vs = run && t < VS_LEN;
        o.hr = run && line >= VF && line < VF + VA && x < HA;
        o.data = !o.hr ? 8'h00 : pat == 0 ? 8'(x) : pat == 1 ? 8'(y) :
                 pat == 2 ? ((((x >> 3) ^ (y >> 3)) & 1) != 0 ? 8'hFF : 8'h00) : 8'(x + int'(fcnt));
        o.fd = run && t == VS_LEN;
        o.busy = run;
        o.fcnt = fcnt;
        return o;
    endfunction

    // reference: a frame is just a position t within a fixed-length period
    initial begin
        bit run = 0;
        int t = 0;
        int pat = 0;
        logic [15:0] fcnt = '0;
        obs_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                run = 0; t = 0; pat = 0; fcnt = '0;
            end else if (!run) begin
                if (gen_en) begin run = 1; t = 0; pat = int'(pattern_sel); end
            end else begin
                t++;
                if (t == FRAME) begin
                    if (gen_en) begin t = 0; pat = int'(pattern_sel); end
                    else begin run = 0; t = 0; end
                end else if (t == VS_LEN) fcnt++;
            end
            e = predict(run, t, pat, fcnt);
            exp_q.push_back(e);
            if (e.hr) pix_q.push_back(e.data);
        end
    end

    initial begin
        obs_t e, a;
        logic [7:0] p;
        forever begin
            @(negedge clk);
            a = '{cmos_vsync, cmos_href, cmos_data, frame_done, busy, frame_cnt};
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL cycle_outputs @%0t: vs/hr/data/fd/busy/fcnt got %b %b %h %b %b %0d, expected %b %b %h %b %b %0d",
                             $time, a.vs, a.hr, a.data, a.fd, a.busy, a.fcnt, e.vs, e.hr, e.data, e.fd, e.busy, e.fcnt);
                end
            end
            if (cmos_href === 1'b1) begin
                vectors++;
                if (pix_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pixel @%0t: got %h with href, expected no pixel", $time, cmos_data);
                end else begin
                    p = pix_q.pop_front();
                    if (cmos_data !== p) begin
                        miscompares++;
                        $display("FAIL pixel @%0t: got %h, expected %h", $time, cmos_data, p);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);
        gen_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            pattern_sel = 2'(f);
            tick(40);
            pattern_sel = 2'($urandom);
            tick(FRAME - 40);
        end
        pattern_sel = 2'd3;
        tick(3 * FRAME);
        tick(40);
        gen_en = 1'b0;
        tick(2 * FRAME);
        gen_en = 1'b1;
        pattern_sel = 2'd1;
        tick(50);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        gen_en = 1'b0;
        tick(5);
        gen_en = 1'b1;
        tick(2 * FRAME);
        for (int i = 0; i < 3000; i++) begin
            gen_en = ($urandom % 8) != 0;
            pattern_sel = 2'($urandom);
            rst = ($urandom % 400) == 0;
            tick(1);
        end
        rst = 1'b0;
        gen_en = 1'b0;
        tick(2 * FRAME);
        vectors++;
        if (pix_q.size() != 0) begin
            miscompares++;
            $display("FAIL pixel_queue_drain: got %0d pending, expected 0", pix_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cmos_dvp_pattern_gen.md
Name: cmos_dvp_pattern_gen

Overview:
- Synthetic DVP camera source: drives vsync/href/8-bit data exactly as an OmniVision-style sensor would, so the capture path can be exercised without a real sensor.
- Sits in place of the sensor pins. Outputs connect directly to a capture block's vsync/href/data inputs, and both run on the same pixel clock.
- Produces selectable RAW/gray test patterns, a frame counter and an end-of-frame pulse.

Parameters:
- H_ACTIVE, 640, pixels per line (href high cycles).
- H_BLANK, 144, href-low cycles after each active run.
- V_FRONT, 16, lines with vsync high before the first active line.
- V_ACTIVE, 480, active lines per frame.
- V_BACK, 8, lines with vsync high after the last active line.
- V_SYNC, 4, lines with vsync low between frames.

Ports:
- clk_cmos  in  1  pixel clock; all outputs change on its rising edge.
- rst  in  1  synchronous, active-high reset.
- gen_en  in  1  run request; frames start only while high.
- pattern_sel  in  2  pattern select; latched at frame start.
- cmos_vsync  out  1  frame valid, high during the frame.
- cmos_href  out  1  line/data valid.
- cmos_data  out  8  pixel data; 0 when href is low.
- frame_done  out  1  one-cycle pulse when vsync falls.
- frame_cnt  out  16  completed frames.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Timing units:
  - Line length H_TOTAL = H_ACTIVE + H_BLANK.
  - pix_cnt runs 0..H_TOTAL-1 and wraps every line in every non-IDLE state.
  - line_cnt counts lines within the current state.
  - Both counters are 12 bits; H_TOTAL and every V_* parameter must be ≤ 4095 and ≥ 1.
- States: IDLE, FRONT, ACTIVE, BACK, SYNC.
- IDLE:
  - vsync = href = 0, data = 0, counters held at 0.
  - If gen_en = 1, next cycle enters FRONT with pix = line = 0. Latency is 1 cycle from gen_en to vsync high.
- FRONT:
  - vsync = 1, href = 0.
  - After V_FRONT full lines, enter ACTIVE.
- ACTIVE:
  - vsync = 1; href = 1 when pix_cnt < H_ACTIVE.
  - After V_ACTIVE lines, enter BACK.
- BACK:
  - vsync = 1, href = 0.
  - After V_BACK lines, enter SYNC.
- SYNC:
  - vsync = 0, href = 0.
  - After V_SYNC lines: if gen_en = 1, go to FRONT (back-to-back frames, no extra cycles); otherwise go to IDLE.
- Frame period: (V_FRONT + V_ACTIVE + V_BACK + V_SYNC) × H_TOTAL cycles. vsync is high for the first (V_FRONT + V_ACTIVE + V_BACK) × H_TOTAL cycles of that period.
- Data: registered with href, same edge. x = pix_cnt, y = active line index (0..V_ACTIVE-1).
  - pattern 0: x[7:0].
  - pattern 1: y[7:0].
  - pattern 2: 8'hFF if x[3]^y[3], else 8'h00.
  - pattern 3: (x + frame_cnt)[7:0], modulo 256.
  - data = 0 whenever href = 0.
- pattern_sel is sampled on the IDLE→FRONT or SYNC→FRONT transition and held for the whole frame. Mid-frame changes have no effect.
- frame_done:
  - High for exactly the first cycle of SYNC, i.e. the cycle in which vsync is first 0.
  - frame_cnt increments on that same edge and wraps 16'hFFFF → 0.
- gen_en deasserted mid-frame: the current frame completes fully, including SYNC, then the block goes to IDLE. A partial frame is never emitted.
- Reset, including mid-frame:
  - Next edge forces IDLE.
  - All outputs go to 0: cmos_vsync, cmos_href, cmos_data, frame_done, busy, frame_cnt.
  - Pattern latch is cleared to 0.
  - No frame_done is generated for the aborted frame.
- busy = 0 only in IDLE.

Test Plan:
Bench params: H_ACTIVE=8, H_BLANK=4, V_FRONT=2, V_ACTIVE=4, V_BACK=1, V_SYNC=1 (H_TOTAL=12, frame=96 cycles).
- Reset, then gen_en=1 at cycle 0 → vsync high cycles 1..84, low 85..96. frame_done=1 only at cycle 85. frame_cnt=1 after cycle 85. Next vsync rise at cycle 97.
- Same run → exactly 4 href pulses of 8 cycles each. First href at cycle 25, pulses at 12-cycle pitch. Pattern 0 data = 0,1,…,7 on every line; data = 0 outside href.
- pattern_sel=1 → line k data constant k (0..3). pattern_sel=2 → all lines 00 for x=0..7 (x[3]=0, y[3]=0). Change pattern_sel mid-frame → no change until the next FRONT.
- pattern 3 over 3 consecutive frames → first pixel of each line = 0, 1, 2 respectively.
- gen_en dropped at cycle 40 → frame completes, frame_done at cycle 85, IDLE from cycle 97, busy=0, vsync stays 0.
- rst at cycle 50 (mid-ACTIVE) → next cycle all outputs 0, no frame_done, frame_cnt=0. Restart with gen_en → normal frame timing from vsync rise.
